// File: rtl/serial_pkg.sv
// serial_pkg: shared state type, default widths and helpers for the serial word link.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } tx_state_t;

    localparam int SERIAL_WIDTH_DEF = 8;
    localparam logic IDLE_LEVEL_DEF = 1'b0;

    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_counter.sv
// bit_counter: modulo-WIDTH counter with synchronous clear and enable.
// terminal flags the last count so frame logic can end on the final bit.
module bit_counter
    import serial_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         enable,
    output logic [cntWidth(WIDTH)-1:0]   count,
    output logic                         terminal
);

    assign terminal = count == cntWidth(WIDTH)'(WIDTH - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= terminal ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/serial_word_transmitter.sv
// serial_word_transmitter: LSB-first parallel-to-serial source for a free-running shift register.
// Optional SERIAL_TX_FRAME_COUNT_EN adds an 8-bit wrapping count of completed frames.
module serial_word_transmitter
    import serial_pkg::*;
#(
    parameter int   WIDTH    = SERIAL_WIDTH_DEF,
    parameter logic IDLE_BIT = IDLE_LEVEL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pIn,
    input  logic             load,
    output logic             ready,
    output logic             sOut,
    output logic             busy,
    output logic             frameDone
`ifdef SERIAL_TX_FRAME_COUNT_EN
    ,
    output logic [7:0]       frameCount
`endif
);

    tx_state_t state, stateNext;
    logic [WIDTH-1:0] shiftReg;
    logic [cntWidth(WIDTH)-1:0] bitCount;
    logic accept, lastBit, unusedCountBits;

    // Outputs decode from registered state only, so load never reaches them combinationally.
    assign ready     = state != SHIFT;
    assign busy      = state == SHIFT;
    assign frameDone = state == DONE;
    assign sOut      = busy ? shiftReg[0] : IDLE_BIT;
    assign accept    = load && ready;
    assign unusedCountBits = ^bitCount;

    bit_counter #(.WIDTH(WIDTH)) u_bitCounter (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .enable   (busy),
        .count    (bitCount),
        .terminal (lastBit)
    );

    always_comb begin
        stateNext = busy ? (lastBit ? DONE : SHIFT) : (accept ? SHIFT : IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            shiftReg <= '0;
        end else begin
            state    <= stateNext;
            shiftReg <= accept ? pIn : busy ? shiftReg >> 1 : shiftReg;
        end
    end

`ifdef SERIAL_TX_FRAME_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            frameCount <= '0;
        else if (frameDone)
            frameCount <= frameCount + 8'd1;
    end
`endif

endmodule

// File: tb/tb_serial_word_transmitter.sv
// tb_serial_word_transmitter: table-driven and scoreboard checks of the serial word transmitter,
// with a behavioural downstream shift register; exercises frameCount when SERIAL_TX_FRAME_COUNT_EN is set.
module tb_serial_word_transmitter;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] pIn;
    logic load;
    logic ready, sOut, busy, frameDone;
    logic [7:0] po;
`ifdef SERIAL_TX_FRAME_COUNT_EN
    logic [7:0] frameCount;
`endif

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    logic bitQ[$];
    logic [7:0] wordQ[$];
    int doneQ[$];

    typedef struct {
        logic [7:0] word;
        logic [7:0] expPo;
        int         expLat;
    } vec_t;
    vec_t vecs[5];

    serial_word_transmitter dut (
        .clk       (clk),
        .rst       (rst),
        .pIn       (pIn),
        .load      (load),
        .ready     (ready),
        .sOut      (sOut),
        .busy      (busy),
        .frameDone (frameDone)
`ifdef SERIAL_TX_FRAME_COUNT_EN
        ,
        .frameCount(frameCount)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        po  <= {sOut, po[7:1]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer: each busy cycle must carry the next queued bit, each strobe the next word.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (busy) begin
                if (bitQ.size() == 0)
                    chk("unexpectedBusy", 1, 0);
                else
                    chk("sOutBit", sOut, bitQ.pop_front());
            end else begin
                chk("sOutIdle", sOut, 1'b0);
            end
            if (frameDone) begin
                doneQ.push_back(cyc);
                if (wordQ.size() == 0)
                    chk("unexpectedDone", 1, 0);
                else
                    chk("poAtDone", po, wordQ.pop_front());
            end
        end
    end

    task automatic drive(input logic [7:0] w, input logic l, output int c);
        @(negedge clk);
        pIn = w;
        load = l;
        c = cyc;
        if (l && ready && rst) begin
            wordQ.push_back(w);
            for (int i = 0; i < 8; i++) bitQ.push_back(w[i]);
        end
    endtask

    initial begin
        int c0, c, lat;
        vecs[0] = '{8'hA5, 8'hA5, 9};
        vecs[1] = '{8'h3C, 8'h3C, 9};
        vecs[2] = '{8'h00, 8'h00, 9};
        vecs[3] = '{8'hFF, 8'hFF, 9};
        vecs[4] = '{8'h96, 8'h96, 9};

        rst = 1'b0;
        load = 1'b0;
        pIn = '0;
        repeat (3) @(negedge clk);
        chk("rstSOut", sOut, 1'b0);
        chk("rstReady", ready, 1'b1);
        chk("rstBusy", busy, 1'b0);
        chk("rstDone", frameDone, 1'b0);
`ifdef SERIAL_TX_FRAME_COUNT_EN
        chk("rstCount", frameCount, 8'd0);
`endif
        rst = 1'b1;
        drive(8'h00, 1'b0, c);

        foreach (vecs[i]) begin
            drive(vecs[i].word, 1'b1, c0);
            lat = -1;
            for (int k = 0; k < 20 && lat < 0; k++) begin
                drive(8'h00, 1'b0, c);
                if (frameDone) lat = c - c0;
            end
            chk("latency", lat, vecs[i].expLat);
            chk("poVec", po, vecs[i].expPo);
            drive(8'h00, 1'b0, c);
            chk("strobeOneCycle", frameDone, 1'b0);
            chk("readyAfterDone", ready, 1'b1);
        end

        // Back-to-back: load held, second word accepted in the DONE cycle.
        doneQ.delete();
        drive(8'h3C, 1'b1, c0);
        repeat (9) drive(8'hC3, 1'b1, c);
        repeat (12) drive(8'h00, 1'b0, c);
        chk("b2bCount", doneQ.size(), 2);
        if (doneQ.size() == 2) begin
            chk("b2bDone1", doneQ[0], c0 + 9);
            chk("b2bDone2", doneQ[1], c0 + 18);
        end

        // Loads during a frame are ignored.
        doneQ.delete();
        drive(8'h00, 1'b1, c0);
        drive(8'h00, 1'b0, c);
        for (int k = 2; k <= 7; k++) begin
            drive(8'hFF, 1'b1, c);
            chk("busyReady", ready, 1'b0);
        end
        repeat (12) drive(8'h00, 1'b0, c);
        chk("ignoreDoneCount", doneQ.size(), 1);
        if (doneQ.size() == 1) chk("ignoreDoneCycle", doneQ[0], c0 + 9);
        chk("ignoreIdle", busy, 1'b0);

        // pIn churn after acceptance must not disturb the frame.
        doneQ.delete();
        drive(8'h81, 1'b1, c0);
        repeat (9) drive(8'($urandom), 1'b0, c);
        repeat (3) drive(8'h00, 1'b0, c);
        chk("stableDoneCount", doneQ.size(), 1);

        // Asynchronous reset in cycle 4 of a frame.
        doneQ.delete();
        drive(8'hA5, 1'b1, c0);
        repeat (4) drive(8'h00, 1'b0, c);
        #2 rst = 1'b0;
        #1;
        chk("abortBusy", busy, 1'b0);
        chk("abortReady", ready, 1'b1);
        chk("abortSOut", sOut, 1'b0);
        chk("abortDone", frameDone, 1'b0);
        bitQ.delete();
        wordQ.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (15) drive(8'h00, 1'b0, c);
        chk("abortNoDone", doneQ.size(), 0);
        chk("abortIdle", busy, 1'b0);

`ifdef SERIAL_TX_FRAME_COUNT_EN
        chk("abortCount", frameCount, 8'd0);
        for (int f = 0; f < 257; f++)
            for (int j = 0; j < 9; j++)
                drive(8'(f) ^ 8'h5A, 1'b1, c);
        repeat (12) drive(8'h00, 1'b0, c);
        chk("countWrap", frameCount, 8'd1);
`endif

        chk("queueDrained", bitQ.size() + wordQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
